// File: rtl/task_manager_pkg.sv
// Shared types and constants for the task_manager endpoint: FSM states,
// error-flag bit positions and the task length width.
package task_manager_pkg;

  localparam int LEN_W = 12;

  localparam int ERR_TIMEOUT  = 2;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_SIZE     = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/task_manager_ram.sv
// Byte-wide simple dual-port RAM: one synchronous write port and one
// registered read port, 2**ADDR_W entries.
module task_manager_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/task_manager.sv
// Manager-side endpoint of the task byte stream: sends a preloaded packet and
// captures the answer. Define TASK_MANAGER_BACKPRESSURE_EN for LFSR answer stalls.
module task_manager
  import task_manager_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_tdata_valid,
  output logic [7:0]        o_tdata,
  output logic              o_tdata_last,
  input  logic              i_tready,
  input  logic              i_tanswer_ready,
  input  logic [7:0]        i_tanswer_data,
  input  logic              i_tanswer_last,
  input  logic [LEN_W-1:0]  i_packet_size,
  output logic              o_tmanager_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_ans_count,
  output logic [2:0]        o_err
);

  localparam int          TMO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_MAX = (1 << LEN_W) - 1;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q, send_idx, next_idx;
  logic [ADDR_W:0]   ans_cnt, ans_cnt_inc;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tx_valid, ans_seen, rd_ok, ans_ready;
  logic [7:0]        pkt_rd_data, ans_rd_data;
  logic              active, accept, send_last, send_xfer, send_last_xfer;
  logic              ans_xfer, ans_last_xfer, ans_full, any_xfer, tmo_hit;

  assign active         = (state == RUN) || (state == DRAIN);
  assign accept         = (state == IDLE) && i_start && (i_len != '0);
  assign send_last      = tx_valid && (send_idx == len_q - 1'b1);
  assign send_xfer      = tx_valid && i_tready;
  assign send_last_xfer = send_xfer && send_last;
  assign ans_xfer       = i_tanswer_ready && ans_ready;
  assign ans_last_xfer  = ans_xfer && i_tanswer_last;
  assign ans_full       = ans_cnt[ADDR_W];
  assign ans_cnt_inc    = ans_full ? ans_cnt : ans_cnt + 1'b1;
  assign any_xfer       = send_xfer || ans_xfer;
  assign tmo_hit        = active && !any_xfer && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Read address looks one byte ahead on a transfer, so the RAM output already
  // holds the next byte; while stalled it re-reads the same byte and stays stable.
  assign next_idx = (send_xfer && !send_last) ? send_idx + 1'b1 : send_idx;

`ifdef TASK_MANAGER_BACKPRESSURE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr;

  always_ff @(posedge i_clk) begin
    if (!i_rst)      lfsr <= LFSR_SEED;
    else if (accept) lfsr <= LFSR_SEED;
    else if (active) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign ans_ready = active && lfsr[0];
`else
  assign ans_ready = active;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = RUN;
      RUN: begin
        if (send_last_xfer) state_nxt = (ans_seen || ans_last_xfer) ? DONE : DRAIN;
        else if (tmo_hit)   state_nxt = DONE;
      end
      DRAIN: if (ans_last_xfer || tmo_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      len_q    <= '0;
      send_idx <= '0;
      tx_valid <= 1'b0;
      ans_cnt  <= '0;
      ans_seen <= 1'b0;
      tmo_cnt  <= '0;
      o_err    <= '0;
      rd_ok    <= 1'b0;
    end else begin
      rd_ok    <= 1'b1;
      tx_valid <= (state == RUN) && (state_nxt == RUN);
      if (accept) begin
        len_q    <= i_len;
        send_idx <= '0;
        ans_cnt  <= '0;
        ans_seen <= 1'b0;
        tmo_cnt  <= '0;
        o_err    <= '0;
      end else if (active) begin
        send_idx <= next_idx;
        tmo_cnt  <= any_xfer ? '0 : tmo_cnt + 1'b1;
        if (ans_xfer) begin
          ans_cnt <= ans_cnt_inc;
          if (ans_full) o_err[ERR_OVERFLOW] <= 1'b1;
          if (i_tanswer_last) begin
            ans_seen        <= 1'b1;
            o_err[ERR_SIZE] <= 32'(ans_cnt_inc) != 32'(i_packet_size);
          end
        end
        if (tmo_hit) o_err[ERR_TIMEOUT] <= 1'b1;
      end
    end
  end

  task_manager_ram #(.ADDR_W(ADDR_W)) u_pkt_ram (
    .clk     (i_clk),
    .wr_en   (i_wr_en),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (ADDR_W'(next_idx)),
    .rd_data (pkt_rd_data)
  );

  task_manager_ram #(.ADDR_W(ADDR_W)) u_ans_ram (
    .clk     (i_clk),
    .wr_en   (ans_xfer && !ans_full),
    .wr_addr (ans_cnt[ADDR_W-1:0]),
    .wr_data (i_tanswer_data),
    .rd_addr (i_rd_addr),
    .rd_data (ans_rd_data)
  );

  // RAM outputs are masked so every output reads zero straight after reset.
  assign o_tdata_valid    = tx_valid;
  assign o_tdata          = tx_valid ? pkt_rd_data : 8'h00;
  assign o_tdata_last     = send_last;
  assign o_tmanager_ready = ans_ready;
  assign o_rd_data        = rd_ok ? ans_rd_data : 8'h00;
  assign o_busy           = (state != IDLE);
  assign o_done           = (state == DONE);

  always_comb begin
    o_ans_count = LEN_W'(ans_cnt);
    if (32'(ans_cnt) > CNT_MAX) o_ans_count = LEN_W'(CNT_MAX);
  end

endmodule
